// File: rtl/kb_event_queue_if.sv
// Keyboard/mouse event queue bus: upstream capture handshake, FWFT consumer side
// and status. The slave modport is the queue itself.
interface kb_event_queue_if #(
   parameter int unsigned DEPTH = 8
);
   logic                     kb_data_ready;
   logic                     kb_is_mouse;
   logic [15:0]              kb_data;
   logic                     kb_data_retrieved;
   logic                     out_valid;
   logic                     out_is_mouse;
   logic [15:0]              out_data;
   logic                     out_ready;
   logic [$clog2(DEPTH):0]   count;
   logic                     overflow;
   logic                     clear_overflow;

   modport master (
      output kb_data_ready, kb_is_mouse, kb_data, out_ready, clear_overflow,
      input  kb_data_retrieved, out_valid, out_is_mouse, out_data, count, overflow
   );

   modport slave (
      input  kb_data_ready, kb_is_mouse, kb_data, out_ready, clear_overflow,
      output kb_data_retrieved, out_valid, out_is_mouse, out_data, count, overflow
   );
endinterface

// File: rtl/kb_event_queue.sv
// Event queue between the keyboard/mouse receiver and its consumer: captures one
// word per upstream ready assertion and presents entries first-word-fall-through.
module kb_event_queue #(
   parameter int unsigned DEPTH = 8
) (
   input logic            clk,
   input logic            reset_n,
   kb_event_queue_if.slave q
);
   localparam int unsigned AW = $clog2(DEPTH);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      ACK      = 2'd1,
      WAIT_LOW = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [AW-1:0]   rd_ptr, wr_ptr;
   logic [AW:0]     count_q;
   logic [16:0]     mem [DEPTH];
   logic            full, wr_en, pop, set_ovf;
   logic            ovf_q, ret_q;

   // Full check uses the registered count, so a same-cycle pop never frees a slot.
   assign full = (count_q == (AW+1)'(DEPTH));
   assign pop  = (count_q != '0) && q.out_ready;

   always_comb begin
      state_d = state_q;
      wr_en   = 1'b0;
      set_ovf = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (q.kb_data_ready) begin
               if (!full) begin
                  wr_en   = 1'b1;
                  state_d = ACK;
               end else begin
                  set_ovf = 1'b1;
               end
            end
         end
         ACK:      state_d = WAIT_LOW;
         WAIT_LOW: if (!q.kb_data_ready) state_d = IDLE;
         default:  state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= IDLE;
         rd_ptr  <= '0;
         wr_ptr  <= '0;
         count_q <= '0;
         ovf_q   <= 1'b0;
         ret_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ret_q   <= (state_d == ACK);
         if (wr_en) wr_ptr <= wr_ptr + AW'(1);
         if (pop)   rd_ptr <= rd_ptr + AW'(1);
         count_q <= count_q + (AW+1)'(wr_en) - (AW+1)'(pop);
         if (set_ovf)                ovf_q <= 1'b1;
         else if (q.clear_overflow)  ovf_q <= 1'b0;
      end
   end

   // Storage is deliberately left out of reset.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr] <= {q.kb_is_mouse, q.kb_data};
   end

   assign q.out_valid         = (count_q != '0);
   assign q.out_is_mouse      = mem[rd_ptr][16];
   assign q.out_data          = mem[rd_ptr][15:0];
   assign q.count             = count_q;
   assign q.overflow          = ovf_q;
   assign q.kb_data_retrieved = ret_q;
endmodule

// File: tb/tb_kb_event_queue.sv
// Self-checking bench for kb_event_queue: directed vector table, hand-written
// corner sequences and randomized traffic against a queue-based reference model.
module tb_kb_event_queue;
   localparam int unsigned DEPTH = 8;

   logic clk = 1'b0;
   logic reset_n;
   always #5 clk = ~clk;

   kb_event_queue_if #(.DEPTH(DEPTH)) bus ();

   kb_event_queue #(.DEPTH(DEPTH)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .q       (bus)
   );

   int tests = 0;
   int fails = 0;

   // Reference model: arrival-ordered queue plus handshake progress
   // (0 = free to take a word, 1 = pulse cycle, 2 = holding until ready drops).
   logic [16:0] mq[$];
   bit          m_ovf;
   bit          m_ret;
   int          m_phase;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_edge(input bit rst_n, input bit rdy, input bit mouse,
                             input logic [15:0] data, input bit ordy, input bit clr);
      bit take, push, setf, popf;
      if (!rst_n) begin
         mq.delete();
         m_ovf   = 1'b0;
         m_ret   = 1'b0;
         m_phase = 0;
      end else begin
         take = (m_phase == 0) && rdy;
         push = take && (mq.size() < DEPTH);
         setf = take && (mq.size() == DEPTH);
         popf = (mq.size() != 0) && ordy;
         if (popf) void'(mq.pop_front());
         if (push) mq.push_back({mouse, data});
         if (setf)     m_ovf = 1'b1;
         else if (clr) m_ovf = 1'b0;
         if (push)                     m_phase = 1;
         else if (m_phase == 1)        m_phase = 2;
         else if (m_phase == 2 && !rdy) m_phase = 0;
         m_ret = (m_phase == 1);
      end
   endtask

   task automatic tick(input bit rst_n, input bit rdy, input bit mouse,
                       input logic [15:0] data, input bit ordy, input bit clr);
      reset_n                = rst_n;
      bus.kb_data_ready      = rdy;
      bus.kb_is_mouse        = mouse;
      bus.kb_data            = data;
      bus.out_ready          = ordy;
      bus.clear_overflow     = clr;
      @(posedge clk);
      model_edge(rst_n, rdy, mouse, data, ordy, clr);
      #1;
      chk("model_count", 32'(bus.count), 32'(mq.size()));
      chk("model_valid", 32'(bus.out_valid), 32'(mq.size() != 0));
      chk("model_ret", 32'(bus.kb_data_retrieved), 32'(m_ret));
      chk("model_ovf", 32'(bus.overflow), 32'(m_ovf));
      if (mq.size() != 0)
         chk("model_head", 32'({bus.out_is_mouse, bus.out_data}), 32'(mq[0]));
   endtask

   task automatic push_word(input bit mouse, input logic [15:0] data);
      tick(1, 1, mouse, data, 0, 0);
      tick(1, 0, 0, 16'h0, 0, 0);
      tick(1, 0, 0, 16'h0, 0, 0);
   endtask

   typedef struct {
      bit          rst_n, rdy, mouse;
      logic [15:0] data;
      bit          ordy, clr;
      int          e_count;
      bit          e_valid;
      logic [15:0] e_data;
      bit          e_mouse, e_ret, e_ovf;
   } vec_t;

   vec_t vt[18];

   initial begin
      int pulses;
      // rst rdy m data      ordy clr | cnt v data     m ret ovf
      vt[0]  = '{0, 0, 0, 16'h0000, 0, 0, 0, 0, 16'h0000, 0, 0, 0};
      vt[1]  = '{1, 1, 0, 16'h3A12, 0, 0, 1, 1, 16'h3A12, 0, 1, 0};
      vt[2]  = '{1, 1, 0, 16'h3A12, 0, 0, 1, 1, 16'h3A12, 0, 0, 0};
      vt[3]  = '{1, 0, 0, 16'h0000, 0, 0, 1, 1, 16'h3A12, 0, 0, 0};
      vt[4]  = '{1, 0, 0, 16'h0000, 1, 0, 0, 0, 16'h0000, 0, 0, 0};
      vt[5]  = '{1, 1, 0, 16'h0001, 0, 0, 1, 1, 16'h0001, 0, 1, 0};
      vt[6]  = '{1, 0, 0, 16'h0000, 0, 0, 1, 1, 16'h0001, 0, 0, 0};
      vt[7]  = '{1, 0, 0, 16'h0000, 0, 0, 1, 1, 16'h0001, 0, 0, 0};
      vt[8]  = '{1, 1, 1, 16'h8102, 0, 0, 2, 1, 16'h0001, 0, 1, 0};
      vt[9]  = '{1, 0, 0, 16'h0000, 0, 0, 2, 1, 16'h0001, 0, 0, 0};
      vt[10] = '{1, 0, 0, 16'h0000, 0, 0, 2, 1, 16'h0001, 0, 0, 0};
      vt[11] = '{1, 1, 0, 16'h0003, 0, 0, 3, 1, 16'h0001, 0, 1, 0};
      vt[12] = '{1, 0, 0, 16'h0000, 0, 0, 3, 1, 16'h0001, 0, 0, 0};
      vt[13] = '{1, 0, 0, 16'h0000, 0, 0, 3, 1, 16'h0001, 0, 0, 0};
      vt[14] = '{1, 0, 0, 16'h0000, 1, 0, 2, 1, 16'h8102, 1, 0, 0};
      vt[15] = '{1, 0, 0, 16'h0000, 1, 0, 1, 1, 16'h0003, 0, 0, 0};
      vt[16] = '{1, 0, 0, 16'h0000, 1, 0, 0, 0, 16'h0000, 0, 0, 0};
      vt[17] = '{1, 0, 0, 16'h0000, 1, 0, 0, 0, 16'h0000, 0, 0, 0};

      reset_n = 1'b0;
      bus.kb_data_ready = 1'b0; bus.kb_is_mouse = 1'b0; bus.kb_data = '0;
      bus.out_ready = 1'b0; bus.clear_overflow = 1'b0;
      m_ovf = 1'b0; m_ret = 1'b0; m_phase = 0;
      repeat (2) @(negedge clk);

      // Single key and arrival order, fixed expectations.
      for (int i = 0; i < 18; i++) begin
         tick(vt[i].rst_n, vt[i].rdy, vt[i].mouse, vt[i].data, vt[i].ordy, vt[i].clr);
         chk($sformatf("vec%0d_count", i), 32'(bus.count), 32'(vt[i].e_count));
         chk($sformatf("vec%0d_valid", i), 32'(bus.out_valid), 32'(vt[i].e_valid));
         chk($sformatf("vec%0d_ret", i), 32'(bus.kb_data_retrieved), 32'(vt[i].e_ret));
         chk($sformatf("vec%0d_ovf", i), 32'(bus.overflow), 32'(vt[i].e_ovf));
         if (vt[i].e_valid)
            chk($sformatf("vec%0d_head", i), 32'({bus.out_is_mouse, bus.out_data}),
                32'({vt[i].e_mouse, vt[i].e_data}));
      end

      // Full queue, overflow, set-beats-clear, capture one cycle after pop.
      tick(0, 0, 0, 16'h0, 0, 0);
      for (int k = 0; k < 8; k++) push_word(k[0], 16'h1100 + 16'(k));
      chk("full_count", 32'(bus.count), 32'd8);
      for (int c = 0; c < 5; c++) begin
         tick(1, 1, 0, 16'h0909, 0, c == 4);
         chk("full_noret", 32'(bus.kb_data_retrieved), 32'd0);
         chk("full_hold", 32'(bus.count), 32'd8);
      end
      chk("ovf_set_wins", 32'(bus.overflow), 32'd1);
      tick(1, 1, 0, 16'h0909, 1, 0);
      chk("pop_no_write", 32'(bus.count), 32'd7);
      chk("pop_no_ret", 32'(bus.kb_data_retrieved), 32'd0);
      tick(1, 1, 0, 16'h0909, 0, 0);
      chk("late_capture_ret", 32'(bus.kb_data_retrieved), 32'd1);
      chk("late_capture_cnt", 32'(bus.count), 32'd8);
      tick(1, 0, 0, 16'h0, 0, 1);
      chk("ovf_cleared", 32'(bus.overflow), 32'd0);
      tick(1, 0, 0, 16'h0, 0, 0);
      chk("ovf_stays_clear", 32'(bus.overflow), 32'd0);
      for (int k = 0; k < 8; k++) tick(1, 0, 0, 16'h0, 1, 0);
      chk("drained", 32'(bus.count), 32'd0);

      // Sticky ready: one word, one pulse.
      tick(0, 0, 0, 16'h0, 0, 0);
      tick(1, 1, 1, 16'h5555, 0, 0);
      pulses = int'(bus.kb_data_retrieved);
      for (int c = 0; c < 10; c++) begin
         tick(1, 1, 1, 16'h5555, 0, 0);
         pulses += int'(bus.kb_data_retrieved);
      end
      chk("sticky_pulses", 32'(pulses), 32'd1);
      chk("sticky_count", 32'(bus.count), 32'd1);
      tick(1, 0, 0, 16'h0, 0, 0);
      push_word(0, 16'h6666);
      chk("sticky_release", 32'(bus.count), 32'd2);

      // Simultaneous push and pop at count 3, wrapping the pointers.
      tick(0, 0, 0, 16'h0, 0, 0);
      for (int k = 0; k < 3; k++) push_word(0, 16'h7000 + 16'(k));
      for (int i = 0; i < 20; i++) begin
         tick(1, 1, i[0], 16'hA000 + 16'(i), 1, 0);
         chk("pushpop_count", 32'(bus.count), 32'd3);
         tick(1, 0, 0, 16'h0, 0, 0);
         tick(1, 0, 0, 16'h0, 0, 0);
      end
      for (int k = 0; k < 3; k++) tick(1, 0, 0, 16'h0, 1, 0);

      // Reset while holding a word in the wait-for-low phase.
      tick(0, 0, 0, 16'h0, 0, 0);
      for (int k = 0; k < 3; k++) push_word(1, 16'hC000 + 16'(k));
      tick(1, 1, 0, 16'hBEEF, 0, 0);
      tick(1, 1, 0, 16'hBEEF, 0, 0);
      tick(1, 1, 0, 16'hBEEF, 0, 0);
      chk("pre_reset_count", 32'(bus.count), 32'd4);
      tick(0, 1, 0, 16'hBEEF, 0, 0);
      chk("rst_count", 32'(bus.count), 32'd0);
      chk("rst_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_ret", 32'(bus.kb_data_retrieved), 32'd0);
      chk("rst_ovf", 32'(bus.overflow), 32'd0);
      tick(1, 1, 0, 16'hBEEF, 0, 0);
      chk("recapture_count", 32'(bus.count), 32'd1);
      chk("recapture_ret", 32'(bus.kb_data_retrieved), 32'd1);
      chk("recapture_data", 32'(bus.out_data), 32'hBEEF);
      tick(1, 0, 0, 16'h0, 0, 0);
      tick(1, 0, 0, 16'h0, 0, 0);

      // Randomized traffic: slow consumer first to reach full, then a fast one.
      for (int i = 0; i < 2000; i++) begin
         tick($urandom_range(0, 199) != 0,
              $urandom_range(0, 99) < 45,
              1'($urandom),
              16'($urandom),
              $urandom_range(0, 99) < ((i < 1000) ? 20 : 60),
              $urandom_range(0, 99) < 4);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/kb_event_queue.md
KB_EVENT_QUEUE -- requirements
Module: kb_event_queue

Interface
REQ-001 Parameter: DEPTH, default 8, number of FIFO entries; SHALL be a power of two, from 2 to 16.
REQ-002 Port: clk  in  1  monitor clock; the only clock; all state SHALL update on posedge clk.
REQ-003 Port: reset_n  in  1  reset; synchronous, active-low.
REQ-004 Port: kb_data_ready  in  1  upstream keyboard/mouse word available.
REQ-005 Port: kb_is_mouse  in  1  upstream word is mouse data (0 = keyboard).
REQ-006 Port: kb_data  in  16  upstream keyboard or mouse word.
REQ-007 Port: kb_data_retrieved  out  1  one-cycle pulse; tells upstream its word was taken.
REQ-008 Port: out_valid  out  1  queue head is valid.
REQ-009 Port: out_is_mouse  out  1  head entry type flag.
REQ-010 Port: out_data  out  16  head entry data.
REQ-011 Port: out_ready  in  1  consumer accepts the head this cycle.
REQ-012 Port: count  out  clog2(DEPTH)+1  number of occupied entries, 0..DEPTH.
REQ-013 Port: overflow  out  1  sticky flag; an upstream word was waiting while the queue was full.
REQ-014 Port: clear_overflow  in  1  clears overflow.

Function
REQ-015 Storage SHALL be DEPTH entries of 17 bits ({is_mouse, data[15:0]}), with wrap-around read/write pointers.
REQ-016 Capture FSM SHALL have three states: IDLE, ACK and WAIT_LOW.
REQ-017 IDLE: if kb_data_ready=1 and count<DEPTH, write {kb_is_mouse, kb_data} at the tail and go to ACK.
REQ-018 IDLE: if kb_data_ready=1 and count==DEPTH, write nothing, stay in IDLE, keep kb_data_retrieved=0 and set overflow=1.
REQ-019 ACK: kb_data_retrieved=1 for exactly this one cycle; next state is WAIT_LOW.
REQ-020 WAIT_LOW: stay until kb_data_ready==0, then go to IDLE; no capture while in WAIT_LOW, so one upstream word is never enqueued twice.
REQ-021 kb_data_retrieved SHALL be registered and SHALL be 1 only in ACK.
REQ-022 The full check SHALL use registered count; a pop in the same cycle does not make room for a write that cycle (the write happens one cycle later).
REQ-023 Output SHALL be first-word-fall-through.
  - out_valid = (count != 0).
  - out_is_mouse and out_data show the head entry, combinationally from the read pointer.
  - Both SHALL be stable while out_valid=1 and out_ready=0.
REQ-024 Pop occurs when out_valid=1 and out_ready=1; it advances the read pointer by 1 mod DEPTH.
REQ-025 out_ready=1 while empty SHALL be ignored; no pointer or count change.
REQ-026 count after a cycle = count + write - pop; a simultaneous write and pop leaves count unchanged.
REQ-027 Capture-to-visible latency: an entry written into an empty queue at edge N SHALL give out_valid=1 after edge N.
REQ-028 Entries SHALL leave in arrival order, keyboard and mouse interleaved as received.
REQ-029 overflow SHALL stay set until clear_overflow=1.
REQ-030 If clear_overflow=1 and the set condition of REQ-018 occur in the same cycle, set SHALL win.
REQ-031 Entry contents SHALL NOT be modified by the block.

Reset
REQ-032 When reset_n=0 at posedge clk:
  - read and write pointers = 0, count = 0, out_valid = 0;
  - overflow = 0, kb_data_retrieved = 0, FSM = IDLE.
REQ-033 Storage contents need not be cleared.
REQ-034 Reset mid-handshake (ACK or WAIT_LOW) SHALL drop any queued entries and return to IDLE.
  - An upstream word still pending after reset SHALL be captured again as a new entry.
REQ-035 While reset_n=0, kb_data_retrieved SHALL be 0 and out_valid SHALL be 0.

Verification
REQ-036 Single key: kb_data_ready=1, kb_is_mouse=0, kb_data=16'h3A12, upstream drops ready one cycle after the retrieved pulse.
  -> one retrieved pulse, then out_valid=1, out_data=16'h3A12, out_is_mouse=0, count=1.
  -> out_ready=1 for one cycle gives count=0.
REQ-037 Order: push 16'h0001 (keyboard), then 16'h8102 (mouse), then 16'h0003 with out_ready=0.
  -> count=3.
  -> with out_ready=1 the outputs read 0001/0, 8102/1, 0003/0 in that order.
REQ-038 Full: push 8 words with out_ready=0, then hold a 9th word ready for 5 cycles.
  -> count=8, no retrieved pulse, overflow=1.
  -> one pop: the 9th word is captured exactly one cycle after the pop cycle, count returns to 8.
REQ-039 Simultaneous push and pop at count=3.
  -> count stays 3; the head advances; the new word lands at the tail.
  -> write pointer wraps 7->0 correctly over 20 push/pop cycles.
REQ-040 Sticky ready: upstream holds kb_data_ready=1 for 10 cycles after the retrieved pulse.
  -> exactly one entry and one retrieved pulse; FSM stays in WAIT_LOW until ready falls.
REQ-041 Reset mid-operation: reset_n=0 for one cycle with count=4 and FSM in WAIT_LOW.
  -> count=0, out_valid=0, overflow=0, FSM=IDLE.
  -> a still-high kb_data_ready is captured afterwards as one new entry.
